uart_tx_fifo: RTL and testbench

Buffered 8N1 UART transmitter. It takes bytes from a producer over a valid/ready interface and queues them in an internal FIFO. It serialises them on uart_tx with no idle gap between queued bytes. It is the standalone transmit path that pairs with the existing 115200-baud receive logic on the 27 MHz board clock, and it replaces hard-coded string senders.

---
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input, circular FIFO,
// back-to-back serialisation on uart_tx.
module uart_tx_fifo #(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             uart_tx,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_count
);

  localparam int CW = $clog2(DELAY_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state;
  logic [CW-1:0]      bitCnt;
  logic [2:0]         bitIdx;
  logic [7:0]         shift;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] rdPtr;
  logic [FIFO_AW-1:0] wrPtr;
  logic               push;
  logic               pop;
  logic               lastTick;
  logic               notEmpty;

  assign notEmpty = fifo_count != '0;
  assign wr_ready = fifo_count != (FIFO_AW+1)'(FIFO_DEPTH);
  assign push     = wr_valid && wr_ready;
  assign lastTick = bitCnt == CW'(DELAY_FRAMES - 1);
  assign busy     = (state != IDLE) || notEmpty;

  // Pop only where a new frame can start: idle, or the last stop-bit tick.
  assign pop = notEmpty &&
               ((state == IDLE) || ((state == STOP) && lastTick));

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      unique case (1'b1)
        push && !pop: fifo_count <= fifo_count + 1'b1;
        pop && !push: fifo_count <= fifo_count - 1'b1;
        default:      fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      bitCnt  <= '0;
      bitIdx  <= '0;
      shift   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          bitCnt  <= '0;
          if (pop) begin
            shift   <= mem[rdPtr];
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (lastTick) begin
            bitCnt  <= '0;
            bitIdx  <= '0;
            uart_tx <= shift[0];
            state   <= DATA;
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        DATA: begin
          if (lastTick) begin
            bitCnt <= '0;
            if (bitIdx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bitIdx  <= bitIdx + 1'b1;
              uart_tx <= shift[1];
              shift   <= shift >> 1;
            end
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        STOP: begin
          if (lastTick) begin
            bitCnt <= '0;
            if (pop) begin
              shift   <= mem[rdPtr];
              uart_tx <= 1'b0;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            bitCnt <= bitCnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a frame-timeline model
// plus an independent line decoder.
module tb_uart_tx_fifo;

  localparam int D  = 4;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int FL = 10 * D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   wrData = '0;
  logic         wrValid = 1'b0;
  logic         wrReady;
  logic         uartTx;
  logic         busy;
  logic [AW:0]  fifoCount;

  uart_tx_fifo #(
    .DELAY_FRAMES(D),
    .FIFO_DEPTH(N),
    .FIFO_AW(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_data(wrData),
    .wr_valid(wrValid),
    .wr_ready(wrReady),
    .uart_tx(uartTx),
    .busy(busy),
    .fifo_count(fifoCount)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  // Model: queued bytes, byte in flight, position inside its frame.
  logic [7:0] mq[$];
  logic [7:0] acc[$];
  logic [7:0] rxQ[$];
  logic [7:0] cur = '0;
  int         frameT = -1;
  bit         lastPush = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                  $time);
  endtask

  function automatic logic expTx();
    int k;
    if (frameT < 0) return 1'b1;
    k = frameT / D;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return cur[k-1];
  endfunction

  task automatic modelReset();
    mq.delete();
    frameT   = -1;
    lastPush = 0;
  endtask

  task automatic step();
    bit push;
    bit pop;
    push = wrValid && (mq.size() != N);
    pop  = (mq.size() != 0) && (frameT < 0 || frameT == FL - 1);
    if (frameT == FL - 1) frameT = -1;
    else if (frameT >= 0) frameT++;
    if (pop) begin
      cur    = mq.pop_front();
      frameT = 0;
    end
    if (push) begin
      mq.push_back(wrData);
      acc.push_back(wrData);
    end
    lastPush = push;
  endtask

  task automatic compareAll();
    check("tx", uartTx, expTx());
    check("ready", wrReady, mq.size() != N);
    check("busy", busy, (frameT >= 0) || (mq.size() != 0));
    check("count", fifoCount, mq.size());
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) step();
    @(negedge clk);
    compareAll();
  endtask

  task automatic drain();
    int n;
    n = 0;
    wrValid = 1'b0;
    while ((frameT >= 0 || mq.size() != 0) && n < 20 * FL) begin
      cycle();
      n++;
    end
    check("drain_timeout", n < 20 * FL, 1);
    repeat (3) cycle();
  endtask

  task automatic checkBytes(string tag);
    check({tag, "_n"}, rxQ.size(), acc.size());
    for (int i = 0; i < acc.size() && i < rxQ.size(); i++)
      check({tag, "_byte"}, rxQ[i], acc[i]);
    rxQ.delete();
    acc.delete();
  endtask

  // Independent decoder: find start bit, sample mid-bit.
  logic       rxAct = 1'b0;
  int         rxT = 0;
  logic [7:0] rxSh = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      rxAct <= 1'b0;
    end else if (!rxAct) begin
      if (uartTx === 1'b0) begin
        rxAct <= 1'b1;
        rxT   <= 1;
      end
    end else begin
      if (rxT % D == D / 2 && rxT / D >= 1 && rxT / D <= 8)
        rxSh <= {uartTx, rxSh[7:1]};
      if (rxT == 9 * D + D / 2) rxQ.push_back(rxSh);
      if (rxT == FL - 1) rxAct <= 1'b0;
      rxT <= rxT + 1;
    end
  end

  initial begin
    int n;
    modelReset();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset
    repeat (50) cycle();

    // Single byte
    wrData = 8'h55; wrValid = 1'b1;
    cycle();
    wrValid = 1'b0;
    drain();
    checkBytes("single");

    // Three back-to-back bytes
    wrValid = 1'b1;
    wrData = 8'h00; cycle();
    wrData = 8'hFF; cycle();
    wrData = 8'hA5; cycle();
    wrValid = 1'b0;
    drain();
    checkBytes("b2b");

    // Continuous offer: stalls, never drops
    wrData = 8'h10; wrValid = 1'b1;
    repeat (8 * FL) begin
      cycle();
      check("cnt_max", fifoCount > N, 0);
      if (lastPush) wrData = wrData + 8'd1;
    end
    drain();
    checkBytes("stream");

    // Random traffic
    repeat (1500) begin
      wrValid = ($urandom_range(0, 99) < 8);
      wrData  = 8'($urandom);
      cycle();
    end
    drain();
    checkBytes("rand");

    // Reset in the middle of a data bit with bytes queued
    wrValid = 1'b1;
    wrData = 8'h3C; cycle();
    wrData = 8'h81; cycle();
    wrData = 8'h7E; cycle();
    wrValid = 1'b0;
    n = 0;
    while (frameT != 5 * D + 1 && n < 4 * FL) begin
      cycle();
      n++;
    end
    check("mid_data_reach", frameT, 5 * D + 1);
    check("queued_before_rst", fifoCount, 2);
    #1 rst_n = 1'b0;
    #1;
    check("async_tx", uartTx, 1);
    check("async_count", fifoCount, 0);
    modelReset();
    repeat (2) cycle();
    #1 rst_n = 1'b1;
    rxQ.delete();
    acc.delete();
    repeat (3 * FL) cycle();
    check("no_residual", rxQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
